cnn_upsample2x_nearest: RTL and testbench
=========================================

Name: cnn_upsample2x_nearest

Overview:
- Streaming 2x nearest-neighbour upsampler for the decoder path. It is the inverse of the stride-2 downsampling done in the encoder residual blocks.
- Input: one raster-ordered, channel-planar pixel stream of IMAGE_WIDTH x IMAGE_HEIGHT per channel.
- Output: each channel plane at 2*IMAGE_WIDTH x 2*IMAGE_HEIGHT. Each pixel is replicated horizontally and each row vertically.
- A single-row line buffer replays each row. Input backpressure (ready_in) absorbs the 4x output-rate expansion.

Parameters:
DATA_WIDTH, 32, pixel word width (opaque; no arithmetic performed)
IMAGE_WIDTH, 16, input columns per row (>=1)
IMAGE_HEIGHT, 16, input rows per channel plane (>=1)
CHANNEL_NUM, 256, channel planes per frame (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
valid_in  input  1  pxl_in valid; transfer occurs only when valid_in && ready_in
pxl_in  input  DATA_WIDTH  input pixel
ready_in  output  1  block can accept a pixel this cycle
pxl_out  output  DATA_WIDTH  registered output pixel
valid_out  output  1  pxl_out valid (single-cycle strobe per output pixel; no output backpressure)
frame_done  output  1  one-cycle pulse concurrent with the last output pixel of the last channel plane

Behaviour:
- Reset:
  - reset low clears, asynchronously: state=S_ROW0, col/row/ch counters=0, phase=0, valid_out=0, frame_done=0, pxl_out=0.
  - Line buffer contents are don't-care.
  - Reset mid-operation abandons the frame. The first transfer after release is column 0, row 0, channel 0.
- ready_in is combinational from state only: ready_in = (state==S_ROW0) && (phase==0). It never depends on valid_in.
- S_ROW0 (first output copy of a row):
  - On a transfer: write pxl_in to linebuf[col]; pxl_out<=pxl_in; valid_out<=1; phase<=1.
  - Next cycle (phase==1): re-emit the same pxl_out with valid_out=1; phase<=0; col++.
  - When phase==0 and there is no transfer: valid_out<=0. Gaps on valid_in produce output gaps and no duplicates.
  - After the phase-1 cycle of col==IMAGE_WIDTH-1: col<=0; go to S_ROW1.
- S_ROW1 (vertical replica):
  - Runs for exactly 2*IMAGE_WIDTH consecutive cycles with valid_out=1 every cycle and ready_in=0.
  - Output sequence: linebuf[0],linebuf[0],linebuf[1],linebuf[1],...
  - The first S_ROW1 output is in the cycle immediately after the last S_ROW0 output, so the stream has no bubble.
  - The linebuf read address is pre-fetched so pxl_out remains a register output.
  - At the end: col<=0; row++. If row wraps at IMAGE_HEIGHT, row<=0 and ch++. If ch wraps at CHANNEL_NUM, ch<=0 and frame_done pulses with the final output. Then return to S_ROW0.
- Latency: first copy of an accepted pixel appears 1 cycle after the transfer edge.
- Throughput: with valid_in held high, one input row takes exactly 4*IMAGE_WIDTH cycles.
- Output per plane: 4*IMAGE_WIDTH*IMAGE_HEIGHT valid_out strobes, in raster order.
- valid_in while ready_in=0: ignored. The producer must hold the pixel until it transfers.
- Counter widths: $clog2 of each bound, minimum 1 bit. Wrap compares use ==bound-1.
- Degenerate IMAGE_WIDTH=1: S_ROW0 has 2 cycles, S_ROW1 has 2 cycles; the same rules apply.

Test Plan:
- W=2,H=2,C=1, valid_in held high, pxl_in 1,2,3,4 -> valid_out stream 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4. ready_in pattern per row is 1,0,1,0,0,0,0,0. frame_done asserted only with the 16th output.
- Same image, valid_in low for 3 cycles between pixels 1 and 2 -> valid_out drops during the gap. Output sequence is unchanged, with no duplicate or lost pixel.
- W=3,H=1,C=2, planes A0..A2 then B0..B2 -> 12 outputs for A, then 12 for B. frame_done fires once, at the 24th output. Counters return to 0.
- Assert reset low during S_ROW1 of row 0 -> valid_out=0 immediately (asynchronous). After release, ready_in=1. Next input 9 yields output 9,9 as col 0 row 0.
- W=1,H=1,C=1, pixel 7 -> outputs 7,7,7,7 in 4 consecutive cycles starting 1 cycle after the transfer. frame_done is high with the 4th output.
- Hold valid_in=1 continuously across a full 16x16x2 frame -> exactly 2048 valid_out strobes, output matches the golden model, and ready_in is never high in S_ROW1.

Source files
------------

// File: rtl/cnn_upsample2x_nearest.sv
// Streaming 2x nearest-neighbour upsampler: each pixel is emitted twice, then the
// buffered row is replayed once more, giving a 2W x 2H plane per input W x H plane.
module cnn_upsample2x_nearest #(
    parameter int DATA_WIDTH   = 32,
    parameter int IMAGE_WIDTH  = 16,
    parameter int IMAGE_HEIGHT = 16,
    parameter int CHANNEL_NUM  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CH_W  = (CHANNEL_NUM  > 1) ? $clog2(CHANNEL_NUM)  : 1;
    // Depth rounded to the full column-counter range so every index value is legal.
    localparam int LB_DEPTH = 1 << COL_W;

    typedef enum logic {S_ROW0 = 1'b0, S_ROW1 = 1'b1} state_t;

    state_t                r_state, w_state_nxt;
    logic [COL_W-1:0]      r_col, w_col_nxt;
    logic [ROW_W-1:0]      r_row, w_row_nxt;
    logic [CH_W-1:0]       r_ch, w_ch_nxt;
    logic                  r_phase, w_phase_nxt;
    logic                  r_valid_out, w_valid_nxt;
    logic                  r_frame_done, w_fd_nxt;
    logic [DATA_WIDTH-1:0] r_pxl_out, w_pxl_nxt;
    logic [DATA_WIDTH-1:0] r_linebuf [LB_DEPTH];

    logic w_xfer, w_lb_we, w_col_last, w_row_last, w_ch_last;

    assign ready_in   = (r_state == S_ROW0) && !r_phase;
    assign w_xfer     = valid_in && ready_in;
    assign w_col_last = (r_col == COL_W'(IMAGE_WIDTH - 1));
    assign w_row_last = (r_row == ROW_W'(IMAGE_HEIGHT - 1));
    assign w_ch_last  = (r_ch == CH_W'(CHANNEL_NUM - 1));

    assign pxl_out    = r_pxl_out;
    assign valid_out  = r_valid_out;
    assign frame_done = r_frame_done;

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_ch_nxt    = r_ch;
        w_phase_nxt = r_phase;
        w_valid_nxt = 1'b0;
        w_fd_nxt    = 1'b0;
        w_pxl_nxt   = r_pxl_out;
        w_lb_we     = 1'b0;
        unique case (r_state)
            S_ROW0: begin
                if (!r_phase) begin
                    if (w_xfer) begin
                        w_lb_we     = 1'b1;
                        w_pxl_nxt   = pxl_in;
                        w_valid_nxt = 1'b1;
                        w_phase_nxt = 1'b1;
                    end
                end else begin
                    // Second horizontal copy: hold pxl_out, re-strobe valid.
                    w_valid_nxt = 1'b1;
                    w_phase_nxt = 1'b0;
                    if (w_col_last) begin
                        w_col_nxt   = '0;
                        w_state_nxt = S_ROW1;
                    end else begin
                        w_col_nxt = r_col + COL_W'(1);
                    end
                end
            end
            S_ROW1: begin
                // Replay linebuf[col] twice; the array read lands in the output register.
                w_valid_nxt = 1'b1;
                w_pxl_nxt   = r_linebuf[r_col];
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    if (w_col_last) begin
                        w_col_nxt   = '0;
                        w_state_nxt = S_ROW0;
                        if (w_row_last) begin
                            w_row_nxt = '0;
                            if (w_ch_last) begin
                                w_ch_nxt = '0;
                                w_fd_nxt = 1'b1;
                            end else begin
                                w_ch_nxt = r_ch + CH_W'(1);
                            end
                        end else begin
                            w_row_nxt = r_row + ROW_W'(1);
                        end
                    end else begin
                        w_col_nxt = r_col + COL_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_ROW0;
            r_col        <= '0;
            r_row        <= '0;
            r_ch         <= '0;
            r_phase      <= 1'b0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            r_pxl_out    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_ch         <= w_ch_nxt;
            r_phase      <= w_phase_nxt;
            r_valid_out  <= w_valid_nxt;
            r_frame_done <= w_fd_nxt;
            r_pxl_out    <= w_pxl_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_lb_we) r_linebuf[r_col] <= pxl_in;
    end

endmodule

// File: tb/tb_cnn_upsample2x_nearest.sv
// Directed bench for cnn_upsample2x_nearest across four geometries (2x2x1, 3x1x2, 1x1x1, 16x16x2).
module tb_cnn_upsample2x_nearest;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]         vin;
    logic [3:0][DW-1:0] pin;
    wire  [3:0]         rdy, vout, fd;
    wire  [3:0][DW-1:0] pout;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] px_q[$], out_q[$], exp_q[$];
    logic          out_fd[$], rec_rdy[$], rec_vo[$], rec_fd[$];

    cnn_upsample2x_nearest #(.DATA_WIDTH(DW), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .CHANNEL_NUM(1)) u_a (
        .clk(clk), .reset(rst_n), .valid_in(vin[0]), .pxl_in(pin[0]), .ready_in(rdy[0]),
        .pxl_out(pout[0]), .valid_out(vout[0]), .frame_done(fd[0]));
    cnn_upsample2x_nearest #(.DATA_WIDTH(DW), .IMAGE_WIDTH(3), .IMAGE_HEIGHT(1), .CHANNEL_NUM(2)) u_b (
        .clk(clk), .reset(rst_n), .valid_in(vin[1]), .pxl_in(pin[1]), .ready_in(rdy[1]),
        .pxl_out(pout[1]), .valid_out(vout[1]), .frame_done(fd[1]));
    cnn_upsample2x_nearest #(.DATA_WIDTH(DW), .IMAGE_WIDTH(1), .IMAGE_HEIGHT(1), .CHANNEL_NUM(1)) u_c (
        .clk(clk), .reset(rst_n), .valid_in(vin[2]), .pxl_in(pin[2]), .ready_in(rdy[2]),
        .pxl_out(pout[2]), .valid_out(vout[2]), .frame_done(fd[2]));
    cnn_upsample2x_nearest #(.DATA_WIDTH(DW), .IMAGE_WIDTH(16), .IMAGE_HEIGHT(16), .CHANNEL_NUM(2)) u_d (
        .clk(clk), .reset(rst_n), .valid_in(vin[3]), .pxl_in(pin[3]), .ready_in(rdy[3]),
        .pxl_out(pout[3]), .valid_out(vout[3]), .frame_done(fd[3]));

    task automatic clear_q();
        px_q.delete(); out_q.delete(); exp_q.delete();
        out_fd.delete(); rec_rdy.delete(); rec_vo.delete(); rec_fd.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vin   = '0;
        pin   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_q();
    endtask

    // Producer holding valid_in high while pixels remain (optionally with a gap);
    // records what instance sel shows in every cycle, sampled on the falling edge.
    task automatic run(input int sel, input int n_cyc, input int gap_after, input int gap_len);
        int idx  = 0;
        int gcnt = 0;
        for (int t = 0; t < n_cyc; t++) begin
            @(negedge clk);
            rec_rdy.push_back(rdy[sel]);
            rec_vo.push_back(vout[sel]);
            rec_fd.push_back(fd[sel]);
            if (vout[sel]) begin
                out_q.push_back(pout[sel]);
                out_fd.push_back(fd[sel]);
            end
            if (idx < px_q.size() && !(idx == gap_after && gcnt < gap_len)) begin
                vin[sel] = 1'b1;
                pin[sel] = px_q[idx];
                if (rdy[sel]) idx++;
            end else begin
                vin[sel] = 1'b0;
                if (idx == gap_after && gcnt < gap_len) gcnt++;
            end
        end
        vin[sel] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vin   = '0;
        pin   = '0;
        #1;
        checks++; if (vout !== 4'b0000) begin errors++; $display("FAIL reset_valid_out got %b want 0000", vout); end
        checks++; if (fd !== 4'b0000) begin errors++; $display("FAIL reset_frame_done got %b want 0000", fd); end
        checks++; if (rdy !== 4'b1111) begin errors++; $display("FAIL reset_ready_in got %b want 1111", rdy); end
        checks++; if (pout[0] !== '0 || pout[3] !== '0) begin errors++; $display("FAIL reset_pxl_out got %h/%h want 0", pout[0], pout[3]); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int bad, nfd;
        logic er;
        do_reset();
        for (int i = 1; i <= 4; i++) px_q.push_back(DW'(i));
        run(0, 20, -1, 0);
        for (int r = 0; r < 2; r++) for (int rep = 0; rep < 2; rep++)
            for (int c = 0; c < 2; c++) for (int k = 0; k < 2; k++) exp_q.push_back(DW'(r * 2 + c + 1));
        checks++; if (out_q.size() != 16) begin errors++; $display("FAIL basic_count got %0d want 16", out_q.size()); end
        bad = -1;
        for (int i = 0; i < 16 && i < out_q.size(); i++) if (bad < 0 && out_q[i] !== exp_q[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL basic_seq idx %0d got %0d want %0d", bad, out_q[bad], exp_q[bad]); end
        bad = -1;
        for (int t = 0; t < 16; t++) begin
            er = ((t % 8) < 4) && (t % 2 == 0);
            if (bad < 0 && rec_rdy[t] !== er) bad = t;
        end
        checks++; if (bad >= 0) begin errors++; $display("FAIL basic_ready cycle %0d got %b", bad, rec_rdy[bad]); end
        bad = -1;
        for (int t = 1; t <= 16; t++) if (bad < 0 && rec_vo[t] !== 1'b1) bad = t;
        checks++; if (bad >= 0 || rec_vo[17] !== 1'b0) begin errors++; $display("FAIL basic_valid_run cycle %0d got %b want 1 over 1..16 then 0", bad, rec_vo[17]); end
        nfd = 0;
        foreach (rec_fd[t]) if (rec_fd[t] === 1'b1) nfd++;
        checks++; if (nfd != 1 || rec_fd[16] !== 1'b1) begin errors++; $display("FAIL basic_frame_done pulses %0d at16 %b want 1 at cycle 16", nfd, rec_fd[16]); end
    endtask

    task automatic test_gap();
        int bad, nfd;
        do_reset();
        for (int i = 1; i <= 4; i++) px_q.push_back(DW'(i));
        run(0, 24, 1, 3);
        for (int r = 0; r < 2; r++) for (int rep = 0; rep < 2; rep++)
            for (int c = 0; c < 2; c++) for (int k = 0; k < 2; k++) exp_q.push_back(DW'(r * 2 + c + 1));
        bad = (out_q.size() != 16) ? 99 : -1;
        for (int i = 0; i < 16 && i < out_q.size(); i++) if (bad < 0 && out_q[i] !== exp_q[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL gap_seq idx %0d count %0d want 16 matching outputs", bad, out_q.size()); end
        checks++; if (rec_vo[3] !== 1'b0 || rec_vo[4] !== 1'b0 || rec_vo[5] !== 1'b1)
            begin errors++; $display("FAIL gap_valid cycles3..5 got %b%b%b want 001", rec_vo[3], rec_vo[4], rec_vo[5]); end
        nfd = 0;
        foreach (rec_fd[t]) if (rec_fd[t] === 1'b1) nfd++;
        checks++; if (nfd != 1 || out_fd[15] !== 1'b1) begin errors++; $display("FAIL gap_frame_done pulses %0d want 1 on last output", nfd); end
    endtask

    task automatic test_multi_channel();
        int bad, nfd;
        do_reset();
        for (int g = 0; g < 2; g++) for (int c = 0; c < 3; c++) px_q.push_back(DW'(10 * (g + 1) + c));
        run(1, 30, -1, 0);
        for (int g = 0; g < 2; g++) for (int rep = 0; rep < 2; rep++)
            for (int c = 0; c < 3; c++) for (int k = 0; k < 2; k++) exp_q.push_back(DW'(10 * (g + 1) + c));
        checks++; if (out_q.size() != 24) begin errors++; $display("FAIL mc_count got %0d want 24", out_q.size()); end
        bad = -1;
        for (int i = 0; i < 24 && i < out_q.size(); i++) if (bad < 0 && out_q[i] !== exp_q[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL mc_seq idx %0d got %0d want %0d", bad, out_q[bad], exp_q[bad]); end
        nfd = 0;
        foreach (rec_fd[t]) if (rec_fd[t] === 1'b1) nfd++;
        checks++; if (nfd != 1 || out_fd.size() != 24 || out_fd[23] !== 1'b1)
            begin errors++; $display("FAIL mc_frame_done pulses %0d want 1 on output 24", nfd); end
        checks++; if (u_b.r_col !== '0 || u_b.r_row !== '0 || u_b.r_ch !== '0 || rdy[1] !== 1'b1)
            begin errors++; $display("FAIL mc_counters col %0d row %0d ch %0d ready %b want 0 0 0 1", u_b.r_col, u_b.r_row, u_b.r_ch, rdy[1]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        px_q.push_back(DW'(5));
        px_q.push_back(DW'(6));
        run(0, 6, -1, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (vout[0] !== 1'b0 || pout[0] !== '0) begin errors++; $display("FAIL midrst_async got valid %b pxl %0d want 0 0", vout[0], pout[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", rdy[0]); end
        clear_q();
        px_q.push_back(DW'(9));
        run(0, 6, -1, 0);
        checks++; if (out_q.size() != 2 || out_q[0] !== DW'(9) || out_q[1] !== DW'(9))
            begin errors++; $display("FAIL midrst_out count %0d first %0d want 2 x 9", out_q.size(), out_q[0]); end
        checks++; if (rec_vo[1] !== 1'b1 || rec_vo[2] !== 1'b1 || rec_vo[3] !== 1'b0)
            begin errors++; $display("FAIL midrst_timing got %b%b%b want 110", rec_vo[1], rec_vo[2], rec_vo[3]); end
    endtask

    task automatic test_width1();
        logic [7:0] vo_bits, fd_bits;
        int bad;
        do_reset();
        px_q.push_back(DW'(7));
        run(2, 8, -1, 0);
        for (int t = 0; t < 8; t++) begin
            vo_bits[t] = rec_vo[t];
            fd_bits[t] = rec_fd[t];
        end
        checks++; if (vo_bits !== 8'b0001_1110) begin errors++; $display("FAIL w1_valid got %b want 00011110", vo_bits); end
        checks++; if (fd_bits !== 8'b0001_0000) begin errors++; $display("FAIL w1_frame_done got %b want 00010000", fd_bits); end
        bad = (out_q.size() != 4) ? 99 : -1;
        foreach (out_q[i]) if (bad < 0 && out_q[i] !== DW'(7)) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL w1_data idx %0d count %0d want four 7s", bad, out_q.size()); end
    endtask

    task automatic test_back_to_back();
        int bad, nfd;
        logic er;
        do_reset();
        for (int ch = 0; ch < 2; ch++) for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++)
            px_q.push_back(32'h5A00_0000 | DW'(ch << 16) | DW'(r << 8) | DW'(c));
        for (int ch = 0; ch < 2; ch++) for (int r = 0; r < 32; r++) for (int c = 0; c < 32; c++)
            exp_q.push_back(32'h5A00_0000 | DW'(ch << 16) | DW'((r / 2) << 8) | DW'(c / 2));
        run(3, 2060, -1, 0);
        checks++; if (out_q.size() != 2048) begin errors++; $display("FAIL full_count got %0d want 2048", out_q.size()); end
        bad = -1;
        for (int i = 0; i < 2048 && i < out_q.size(); i++) if (bad < 0 && out_q[i] !== exp_q[i]) bad = i;
        checks++; if (bad >= 0) begin errors++; $display("FAIL full_seq idx %0d got %h want %h", bad, out_q[bad], exp_q[bad]); end
        bad = -1;
        for (int t = 0; t < 2048; t++) begin
            er = ((t % 64) < 32) && (t % 2 == 0);
            if (bad < 0 && rec_rdy[t] !== er) bad = t;
        end
        checks++; if (bad >= 0) begin errors++; $display("FAIL full_ready cycle %0d got %b", bad, rec_rdy[bad]); end
        nfd = 0;
        foreach (rec_fd[t]) if (rec_fd[t] === 1'b1) nfd++;
        checks++; if (nfd != 1 || out_fd.size() != 2048 || out_fd[2047] !== 1'b1)
            begin errors++; $display("FAIL full_frame_done pulses %0d want 1 on output 2048", nfd); end
    endtask

    initial begin
        rst_n = 1'b0;
        vin   = '0;
        pin   = '0;
        test_reset();
        test_basic();
        test_gap();
        test_multi_channel();
        test_reset_mid();
        test_width1();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
